mul_div_seq_unit: RTL and testbench
===================================

Name: mul_div_seq_unit

Overview:
- Iterative RV32/RV64 M-extension execution unit in EX.
- Accepts one MUL/DIV/REM operation per start pulse and computes it one bit per cycle.
- Drives the busy/done handshake that the hazard detection unit samples as mul_div_busy.
- Holds the result stable for the ID/EX and EX/MEM hold logic until the next start.

Parameters:
- XLEN, 32, operand and result width; legal values 32 and 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch an operation; sampled only in IDLE or DONE.
- kill  in  1  abort the in-flight operation (pipeline flush or trap).
- funct3  in  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  in  XLEN  rs1 value; captured when start is accepted.
- operand_b  in  XLEN  rs2 value; captured when start is accepted.
- busy  out  1  operation in progress.
- done  out  1  single-cycle pulse; result is valid in that cycle.
- result  out  XLEN  final result; held until the next accepted start.

Behaviour:
- Reset values: state IDLE, busy 0, done 0, result 0, all internal registers 0.
- States:
  - IDLE.
  - COMPUTE: busy=1.
  - DONE: done=1, busy=0.
- busy is a registered output and equals (state==COMPUTE).
- done is a registered output and equals (state==DONE).
- Accepting a start (state IDLE or DONE, start=1, kill=0):
  - Capture funct3.
  - Capture |a| and |b| as unsigned magnitudes. A is signed for funct3 1, 2, 4, 6. B is signed for funct3 1, 4, 6.
  - Record the result sign:
    - Multiply: sa^sb.
    - Quotient: sa^sb.
    - Remainder: sa.
  - Load count = XLEN and enter COMPUTE.
- Early-out on start; the unit enters DONE directly in the next cycle (latency 1):
  - Divide by zero (b==0):
    - DIV/DIVU give all-ones.
    - REM/REMU give operand_a.
  - Signed overflow (funct3 4 or 6, a==most-negative, b==all-ones):
    - DIV gives most-negative.
    - REM gives 0.
- Multiply, in COMPUTE:
  - Shift-add on a 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
  - The final 2*XLEN product is negated when the sign is negative.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide, in COMPUTE:
  - Restoring division, one quotient bit per cycle, MSB first.
  - XLEN-bit remainder register with one extra bit for the trial subtract.
  - Quotient and remainder are negated per their sign flags at completion.
- count decrements every COMPUTE cycle.
- When count==1, the last iteration executes, result is registered, and the next state is DONE.
- Normal latency: done asserts exactly XLEN+1 cycles after the start cycle (cycle 33 for XLEN=32).
- busy is high for cycles 1..XLEN.
- DONE lasts one cycle. Next state is IDLE, or COMPUTE/DONE if start is accepted in that same cycle (back-to-back operation).
- start while in COMPUTE is ignored; no queuing.
- kill in any state forces IDLE:
  - No done is produced.
  - result keeps its previous value.
  - kill has priority over start and over completion in the same cycle.
- reset asserted mid-operation: IDLE next cycle with all outputs at reset values. No done pulse for the aborted operation.
- result updates only on the transition into DONE.

Test Plan:
- MUL 7 x -3 (XLEN=32): start, then 32 busy cycles -> done at cycle 33, result=0xFFFFFFEB, busy=0 in the done cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIV -7/2 -> quotient 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done at cycle 33.
- DIV 5/0 -> done at cycle 1, result=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM of the same operands -> 0.
- Back-to-back: start asserted during the done cycle of DIVU 100/7 -> second op accepted with no IDLE gap. start pulsed at cycle 10 of a busy op -> ignored, first result unchanged.
- kill at cycle 15 of a DIV -> busy=0 next cycle, no done ever, result unchanged. reset at cycle 20 -> all outputs 0 next cycle; a new op then runs correctly.

Source files
------------

// File: rtl/mul_div_seq_unit.sv
// Iterative RV32/RV64 M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// busy/done are registered; result holds until the next accepted operation completes.
module mul_div_seq_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]        op;
    logic [2*XLEN-1:0] prod, mcand;
    logic [XLEN-1:0]   opa, opb, rem;
    logic [CW-1:0]     count;
    logic              neg_q, neg_r;

    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag, early_res;
    logic            div0, ovf, early, accept, last;

    logic [2*XLEN-1:0] prod_nx, prod_fin;
    logic [XLEN:0]     rem_sh, diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_nx, quo_nx, fin_res;

    // Operand decode and the short-circuit cases that bypass COMPUTE
    always_comb begin
        a_signed  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_signed  = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sa        = a_signed & operand_a[XLEN-1];
        sb        = b_signed & operand_b[XLEN-1];
        a_mag     = sa ? -operand_a : operand_a;
        b_mag     = sb ? -operand_b : operand_b;
        div0      = funct3[2] && (operand_b == '0);
        ovf       = funct3[2] && !funct3[0] && (operand_a == MOST_NEG) && (operand_b == '1);
        early     = div0 || ovf;
        early_res = '0;
        if (div0)
            early_res = funct3[1] ? operand_a : '1;
        else
            early_res = funct3[1] ? '0 : MOST_NEG;
    end

    assign accept = start && !kill && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (state == S_COMPUTE) && (count == CW'(1));

    // One iteration of each algorithm; the final-cycle result is taken straight from these
    always_comb begin
        prod_nx  = prod + (opb[0] ? mcand : '0);
        prod_fin = neg_q ? -prod_nx : prod_nx;
        rem_sh   = {rem, opa[XLEN-1]};
        diff     = rem_sh - {1'b0, opb};
        qbit     = ~diff[XLEN];
        rem_nx   = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx   = {opa[XLEN-2:0], qbit};
        fin_res  = '0;
        if (op[2]) begin
            if (op[1])
                fin_res = neg_r ? -rem_nx : rem_nx;
            else
                fin_res = neg_q ? -quo_nx : quo_nx;
        end else begin
            fin_res = (op == 3'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept)
                        state_nxt = early ? S_DONE : S_COMPUTE;
                    else
                        state_nxt = S_IDLE;
                end
                S_COMPUTE: state_nxt = last ? S_DONE : S_COMPUTE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_COMPUTE);
            done  <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op     <= '0;
            prod   <= '0;
            mcand  <= '0;
            opa    <= '0;
            opb    <= '0;
            rem    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            op    <= funct3;
            prod  <= '0;
            mcand <= {{XLEN{1'b0}}, a_mag};
            opa   <= a_mag;
            opb   <= b_mag;
            rem   <= '0;
            count <= CW'(XLEN);
            neg_q <= sa ^ sb;
            neg_r <= sa;
            if (early)
                result <= early_res;
        end else if ((state == S_COMPUTE) && !kill) begin
            count <= count - CW'(1);
            if (op[2]) begin
                rem <= rem_nx;
                opa <= quo_nx;
            end else begin
                prod  <= prod_nx;
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
            if (last)
                result <= fin_res;
        end
    end

endmodule

// File: tb/tb_mul_div_seq_unit.sv
// Scoreboard bench for mul_div_seq_unit: stimulus pushes expected result/latency, monitor checks on done.
module tb_mul_div_seq_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a, operand_b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    mul_div_seq_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        int              lat;
        int              t0;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result 0x%0h, required no done", result);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_latency"}, cyc - e.t0, e.lat);
                chk({e.name, "_busy_in_done"}, busy, 0);
            end
        end
    end

    task automatic launch(input string nm, input logic [2:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] r, input int lat,
                          input bit expect_done);
        exp_t e;
        start = 1'b1; funct3 = f; operand_a = a; operand_b = b;
        if (expect_done) begin
            e.name = nm; e.res = r; e.lat = lat; e.t0 = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        bit  saw;
        reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);

        // MUL 7 * -3 with busy-cycle count
        @(posedge clk); #1;
        launch("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) nb++;
        end
        chk("mul_busy_cycles", nb, 32);
        wait_drain("mul");

        launch("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1); wait_drain("mulhu");
        launch("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1); wait_drain("mulhsu");
        launch("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1); wait_drain("mulh");
        launch("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1); wait_drain("div");
        launch("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1); wait_drain("rem");
        launch("div0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1); wait_drain("div0");
        launch("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1, 1); wait_drain("remu0");
        launch("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1); wait_drain("div_ovf");
        launch("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 1); wait_drain("rem_ovf");

        // Back-to-back: the second start lands in the done cycle of DIVU
        launch("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1);
        wait_drain("divu");
        launch("remu_b2b", 3'd7, 32'd100, 32'd7, 32'd2, 33, 1);
        chk("b2b_no_gap_busy", busy, 1);
        wait_drain("remu_b2b");

        // start during COMPUTE is ignored
        launch("div_ign", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; funct3 = 3'd5; operand_a = 32'd1; operand_b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain("div_ign");

        // kill at cycle 15: no done, result keeps 0xFFFFFFFD
        launch("kill", 3'd4, 32'd100, 32'd7, 32'd0, 0, 0);
        repeat (14) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("kill_no_done", saw, 0);
        chk("kill_result_held", result, 32'hFFFFFFFD);

        // reset at cycle 20 of a MUL
        #1;
        launch("rst", 3'd0, 32'd7, 32'd9, 32'd0, 0, 0);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        launch("mul_after_rst", 3'd0, 32'd6, 32'd9, 32'd54, 33, 1);
        wait_drain("mul_after_rst");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
